// File: rtl/gtxe2_comm_qpll_pkg.sv
`timescale 1ns/1fs
// Shared state encoding, default constants and Gray-code helpers for the QPLL lock detector.
package gtxe2_comm_qpll_pkg;

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_ACQUIRE  = 2'd1,
    ST_LOCKED   = 2'd2
  } lock_state_t;

  localparam int unsigned DEF_WINDOW       = 1024;
  localparam int unsigned DEF_FB_EXPECT    = 32768;
  localparam int unsigned DEF_TOLERANCE    = 64;
  localparam int unsigned DEF_LOCK_WINDOWS = 3;
  localparam int unsigned DEF_CNT_W        = 20;

  // Helpers work on a fixed 32-bit container; callers zero-extend and truncate.
  localparam int unsigned GRAY_W = 32;

  function automatic logic [GRAY_W-1:0] bin2gray(input logic [GRAY_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [GRAY_W-1:0] gray2bin(input logic [GRAY_W-1:0] g);
    logic [GRAY_W-1:0] b;
    b[GRAY_W-1] = g[GRAY_W-1];
    for (int i = GRAY_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gtxe2_gray_cnt_sync.sv
`timescale 1ns/1fs
// fb_clk edge counter, carried into ref_clk as Gray code through two flops and decoded back to binary.
module gtxe2_gray_cnt_sync
  import gtxe2_comm_qpll_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             fb_clk,
  input  logic             ref_clk,
  input  logic             reset,
  output logic [CNT_W-1:0] count_bin
);

  logic [CNT_W-1:0] bin_cnt;
  logic [CNT_W-1:0] bin_nx;
  logic [CNT_W-1:0] gray_fb;
  logic [CNT_W-1:0] gray_s1;
  logic [CNT_W-1:0] gray_s2;

  assign bin_nx = bin_cnt + CNT_W'(1);

  // Gray register tracks the new count so the last edge before fb stops is not lost.
  always_ff @(posedge fb_clk or posedge reset) begin
    if (reset) begin
      bin_cnt <= '0;
      gray_fb <= '0;
    end else begin
      bin_cnt <= bin_nx;
      gray_fb <= CNT_W'(bin2gray(GRAY_W'(bin_nx)));
    end
  end

  always_ff @(posedge ref_clk or posedge reset) begin
    if (reset) begin
      gray_s1 <= '0;
      gray_s2 <= '0;
    end else begin
      gray_s1 <= gray_fb;
      gray_s2 <= gray_s1;
    end
  end

  assign count_bin = CNT_W'(gray2bin(GRAY_W'(gray_s2)));

endmodule

// File: rtl/gtxe2_comm_qpll_lockdet.sv
`timescale 1ns/1fs
// Frequency lock detector: counts fb_clk edges per ref_clk window and declares QPLL lock
// after LOCK_WINDOWS consecutive in-tolerance windows; flags a dead feedback clock.
module gtxe2_comm_qpll_lockdet
  import gtxe2_comm_qpll_pkg::*;
#(
  parameter int unsigned WINDOW       = DEF_WINDOW,
  parameter int unsigned FB_EXPECT    = DEF_FB_EXPECT,
  parameter int unsigned TOLERANCE    = DEF_TOLERANCE,
  parameter int unsigned LOCK_WINDOWS = DEF_LOCK_WINDOWS,
  parameter int unsigned CNT_W        = DEF_CNT_W
) (
  input  logic             ref_clk,
  input  logic             reset,
  input  logic             fb_clk,
  input  logic             lock_en,
  output logic             lock,
  output logic             fbclk_lost,
  output logic [CNT_W-1:0] freq_count,
  output logic             count_valid
);

  localparam int unsigned          WIN_W    = (WINDOW > 2) ? $clog2(WINDOW) : 1;
  localparam logic [WIN_W-1:0]     WIN_LAST = WIN_W'(WINDOW - 1);
  localparam logic signed [CNT_W:0] EXP_S   = (CNT_W+1)'(FB_EXPECT);
  localparam logic signed [CNT_W:0] TOL_S   = (CNT_W+1)'(TOLERANCE);
  localparam logic [3:0]           LOCK_N   = 4'(LOCK_WINDOWS);

  lock_state_t             state;
  lock_state_t             state_nx;
  logic [3:0]              good_cnt;
  logic [3:0]              good_cnt_nx;
  logic [WIN_W-1:0]        win_cnt;
  logic [CNT_W-1:0]        sync_cnt;
  logic [CNT_W-1:0]        prev_cap;
  logic                    base_vld;
  logic                    run;
  logic                    win_end;
  logic signed [CNT_W:0]   dev;
  logic                    win_good;

  gtxe2_gray_cnt_sync #(
    .CNT_W (CNT_W)
  ) u_sync (
    .fb_clk    (fb_clk),
    .ref_clk   (ref_clk),
    .reset     (reset),
    .count_bin (sync_cnt)
  );

  // Windows only run once the FSM has left DISABLED, so the first window is a full baseline.
  assign run     = lock_en && (state != ST_DISABLED);
  assign win_end = run && (win_cnt == WIN_LAST);

  always_ff @(posedge ref_clk or posedge reset) begin
    if (reset) begin
      win_cnt     <= '0;
      base_vld    <= 1'b0;
      prev_cap    <= '0;
      freq_count  <= '0;
      count_valid <= 1'b0;
    end else begin
      count_valid <= 1'b0;
      if (!run) begin
        win_cnt  <= '0;
        base_vld <= 1'b0;
      end else begin
        win_cnt <= win_end ? '0 : win_cnt + WIN_W'(1);
        if (win_end) begin
          prev_cap <= sync_cnt;
          base_vld <= 1'b1;
          if (base_vld) begin
            freq_count  <= sync_cnt - prev_cap;
            count_valid <= 1'b1;
          end
        end
      end
    end
  end

  // Zero-extended so the deviation keeps its sign for counts on either side of FB_EXPECT.
  assign dev      = $signed({1'b0, freq_count}) - EXP_S;
  assign win_good = (freq_count != '0) && (dev >= -TOL_S) && (dev <= TOL_S);

  always_comb begin
    state_nx    = state;
    good_cnt_nx = good_cnt;
    if (!lock_en) begin
      state_nx    = ST_DISABLED;
      good_cnt_nx = '0;
    end else begin
      unique case (state)
        ST_DISABLED: begin
          state_nx    = ST_ACQUIRE;
          good_cnt_nx = '0;
        end
        ST_ACQUIRE: begin
          if (count_valid) begin
            if (win_good) begin
              good_cnt_nx = good_cnt + 4'd1;
              if (good_cnt_nx == LOCK_N) begin
                state_nx = ST_LOCKED;
              end
            end else begin
              good_cnt_nx = '0;
            end
          end
        end
        ST_LOCKED: begin
          if (count_valid && !win_good) begin
            good_cnt_nx = '0;
            state_nx    = ST_ACQUIRE;
          end
        end
        default: begin
          state_nx    = ST_DISABLED;
          good_cnt_nx = '0;
        end
      endcase
    end
  end

  always_ff @(posedge ref_clk or posedge reset) begin
    if (reset) begin
      state      <= ST_DISABLED;
      good_cnt   <= '0;
      lock       <= 1'b0;
      fbclk_lost <= 1'b0;
    end else begin
      state    <= state_nx;
      good_cnt <= good_cnt_nx;
      lock     <= (state_nx == ST_LOCKED);
      if (lock_en && count_valid) begin
        fbclk_lost <= (freq_count == '0);
      end
    end
  end

endmodule

// File: tb/tb_gtxe2_comm_qpll_lockdet.sv
`timescale 1ns/1fs
// Directed bench for the QPLL lock detector: acquisition, fb loss, tolerance, enable drop, reset and wrap.
module tb_gtxe2_comm_qpll_lockdet;

  localparam int unsigned CNT_W = 20;
  localparam real HALF_2048 = 0.15625;
  localparam real HALF_2070 = 320.0 / 2070.0;
  localparam real HALF_2060 = 320.0 / 2060.0;
  localparam real HALF_FAST = 0.005;

  logic             ref_clk = 1'b0;
  logic             reset = 1'b0;
  logic             fb_clk = 1'b0;
  logic             lock_en = 1'b0;
  logic             lock;
  logic             fbclk_lost;
  logic [CNT_W-1:0] freq_count;
  logic             count_valid;

  int tests = 0;
  int fails = 0;

  real         fb_half  = HALF_2048;
  bit          fb_on    = 1'b0;
  int unsigned fb_edges = 0;
  int unsigned fb_limit = 0;

  gtxe2_comm_qpll_lockdet #(
    .WINDOW       (64),
    .FB_EXPECT    (2048),
    .TOLERANCE    (16),
    .LOCK_WINDOWS (3),
    .CNT_W        (CNT_W)
  ) dut (
    .ref_clk     (ref_clk),
    .reset       (reset),
    .fb_clk      (fb_clk),
    .lock_en     (lock_en),
    .lock        (lock),
    .fbclk_lost  (fbclk_lost),
    .freq_count  (freq_count),
    .count_valid (count_valid)
  );

  always #5 ref_clk = ~ref_clk;

  // Feedback clock: free-running or a burst of exactly fb_limit rising edges.
  always begin
    if (fb_on) begin
      #(fb_half) fb_clk = 1'b1;
      fb_edges++;
      #(fb_half) fb_clk = 1'b0;
      if (fb_limit != 0 && fb_edges >= fb_limit) fb_on = 1'b0;
    end else begin
      @(posedge fb_on);
    end
  end

  task automatic wait_cv(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge ref_clk);
      if (count_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Call right after setting lock_en at a negedge; edge numbers count from the next posedge.
  task automatic run_to_lock(input int budget, input int lo, input int hi,
                             output int lock_edge, output int cv_first,
                             output int cv_n, output bit fc_ok);
    lock_edge = -1;
    cv_first  = -1;
    cv_n      = 0;
    fc_ok     = 1'b1;
    for (int k = 1; k <= budget; k++) begin
      @(negedge ref_clk);
      if (count_valid) begin
        cv_n++;
        if (cv_first < 0) cv_first = k;
        if (int'(freq_count) < lo || int'(freq_count) > hi) fc_ok = 1'b0;
      end
      if (lock && lock_edge < 0) begin
        lock_edge = k;
        break;
      end
    end
  endtask

  task automatic preload(input int unsigned n);
    fb_on = 1'b0;
    @(negedge ref_clk);
    @(negedge ref_clk);
    reset = 1'b1;
    fb_edges = 0;
    @(negedge ref_clk);
    reset = 1'b0;
    fb_limit = n;
    fb_half = HALF_FAST;
    fb_on = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge ref_clk);
      if (!fb_on) break;
    end
    tests++;
    if (fb_on !== 1'b0) begin
      fails++;
      $display("FAIL preload_done: fb burst still running, edges %0d of %0d", fb_edges, n);
    end
  endtask

  task automatic test_reset;
    #1 reset = 1'b1;
    @(negedge ref_clk);
    tests++; if (lock !== 1'b0) begin fails++; $display("FAIL reset_lock: got %b expected 0", lock); end
    tests++; if (fbclk_lost !== 1'b0) begin fails++; $display("FAIL reset_fbclk_lost: got %b expected 0", fbclk_lost); end
    tests++; if (freq_count !== '0) begin fails++; $display("FAIL reset_freq_count: got %0d expected 0", freq_count); end
    tests++; if (count_valid !== 1'b0) begin fails++; $display("FAIL reset_count_valid: got %b expected 0", count_valid); end
    tests++; if (dut.win_cnt !== '0) begin fails++; $display("FAIL reset_win_cnt: got %0d expected 0", dut.win_cnt); end
    fb_half = HALF_2048;
    fb_on = 1'b1;
    @(negedge ref_clk);
  endtask

  task automatic test_acquire;
    int le, cf, cn;
    bit fo;
    reset = 1'b0;
    lock_en = 1'b1;
    run_to_lock(300, 2046, 2050, le, cf, cn, fo);
    tests++; if (le !== 258) begin fails++; $display("FAIL acquire_lock_edge: got %0d expected 258", le); end
    tests++; if (cf !== 129) begin fails++; $display("FAIL acquire_first_cv: got %0d expected 129", cf); end
    tests++; if (cn !== 3) begin fails++; $display("FAIL acquire_cv_count: got %0d expected 3", cn); end
    tests++; if (!fo) begin fails++; $display("FAIL acquire_freq_count: last %0d expected 2046..2050", freq_count); end
    tests++; if (fbclk_lost !== 1'b0) begin fails++; $display("FAIL acquire_fbclk_lost: got %b expected 0", fbclk_lost); end
  endtask

  task automatic test_fb_loss;
    bit ok;
    bit found;
    wait_cv(70, ok);
    fb_on = 1'b0;
    found = 1'b0;
    for (int w = 0; w < 4 && !found; w++) begin
      wait_cv(70, ok);
      if (ok && freq_count == '0) found = 1'b1;
    end
    tests++; if (!found) begin fails++; $display("FAIL loss_zero_window: got freq_count %0d expected 0", freq_count); end
    tests++; if (fbclk_lost !== 1'b0) begin fails++; $display("FAIL loss_lost_early: got %b expected 0 at E+1", fbclk_lost); end
    @(negedge ref_clk);
    tests++; if (fbclk_lost !== 1'b1) begin fails++; $display("FAIL loss_lost_set: got %b expected 1", fbclk_lost); end
    tests++; if (lock !== 1'b0) begin fails++; $display("FAIL loss_lock_drop: got %b expected 0", lock); end
    fb_half = HALF_2048;
    fb_on = 1'b1;
    found = 1'b0;
    for (int w = 0; w < 4 && !found; w++) begin
      wait_cv(70, ok);
      if (ok && freq_count != '0) found = 1'b1;
    end
    tests++; if (!found || fbclk_lost !== 1'b1) begin fails++; $display("FAIL loss_restart_window: found %b lost %b expected 1 1", found, fbclk_lost); end
    @(negedge ref_clk);
    tests++; if (fbclk_lost !== 1'b0) begin fails++; $display("FAIL loss_lost_clear: got %b expected 0", fbclk_lost); end
    for (int w = 0; w < 3; w++) wait_cv(70, ok);
    tests++; if (!ok || lock !== 1'b0) begin fails++; $display("FAIL loss_relock_early: cv %b lock %b expected 1 0", ok, lock); end
    @(negedge ref_clk);
    tests++; if (lock !== 1'b1) begin fails++; $display("FAIL loss_relock: got %b expected 1", lock); end
  endtask

  task automatic test_tolerance;
    int le, cf, cn;
    bit fo;
    lock_en = 1'b0;
    fb_half = HALF_2070;
    repeat (2) @(negedge ref_clk);
    lock_en = 1'b1;
    run_to_lock(520, 2068, 2072, le, cf, cn, fo);
    tests++; if (le !== -1) begin fails++; $display("FAIL tol_2070_lock: lock at edge %0d expected never", le); end
    tests++; if (cn !== 7) begin fails++; $display("FAIL tol_2070_cv_count: got %0d expected 7", cn); end
    tests++; if (!fo) begin fails++; $display("FAIL tol_2070_freq_count: last %0d expected 2068..2072", freq_count); end
    tests++; if (dut.good_cnt !== 4'd0) begin fails++; $display("FAIL tol_2070_good_cnt: got %0d expected 0", dut.good_cnt); end
    lock_en = 1'b0;
    fb_half = HALF_2060;
    repeat (2) @(negedge ref_clk);
    lock_en = 1'b1;
    run_to_lock(300, 2058, 2062, le, cf, cn, fo);
    tests++; if (le !== 258) begin fails++; $display("FAIL tol_2060_lock_edge: got %0d expected 258", le); end
    tests++; if (!fo) begin fails++; $display("FAIL tol_2060_freq_count: last %0d expected 2058..2062", freq_count); end
  endtask

  task automatic test_lock_en_drop;
    int le, cf, cn, cv_seen;
    bit fo;
    repeat (25) @(negedge ref_clk);
    lock_en = 1'b0;
    @(negedge ref_clk);
    tests++; if (lock !== 1'b0) begin fails++; $display("FAIL drop_lock: got %b expected 0", lock); end
    cv_seen = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge ref_clk);
      if (count_valid) cv_seen++;
    end
    tests++; if (cv_seen !== 0) begin fails++; $display("FAIL drop_no_cv: got %0d pulses expected 0", cv_seen); end
    lock_en = 1'b1;
    run_to_lock(300, 2058, 2062, le, cf, cn, fo);
    tests++; if (le !== 258) begin fails++; $display("FAIL drop_relock_edge: got %0d expected 258", le); end
    tests++; if (cf !== 129) begin fails++; $display("FAIL drop_baseline: first cv %0d expected 129", cf); end
  endtask

  task automatic test_reset_midwindow;
    int le, cf, cn;
    bit fo;
    bit got;
    preload(32'd1048476);
    fb_limit = 0;
    fb_half = HALF_2048;
    fb_on = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 700 && !got; i++) begin
      @(negedge ref_clk);
      if (lock) got = 1'b1;
    end
    tests++; if (!got) begin fails++; $display("FAIL rst_prelock: lock %b expected 1 before reset", lock); end
    repeat (20) @(negedge ref_clk);
    #2 reset = 1'b1;
    #1;
    tests++; if (lock !== 1'b0 || fbclk_lost !== 1'b0 || count_valid !== 1'b0) begin
      fails++; $display("FAIL rst_async_flags: lock %b lost %b cv %b expected 0 0 0", lock, fbclk_lost, count_valid);
    end
    tests++; if (freq_count !== '0) begin fails++; $display("FAIL rst_async_freq_count: got %0d expected 0", freq_count); end
    tests++; if (dut.win_cnt !== '0) begin fails++; $display("FAIL rst_async_win_cnt: got %0d expected 0", dut.win_cnt); end
    @(negedge ref_clk);
    reset = 1'b0;
    run_to_lock(300, 2046, 2050, le, cf, cn, fo);
    tests++; if (le !== 258 || cf !== 129) begin fails++; $display("FAIL rst_relock: lock edge %0d first cv %0d expected 258 129", le, cf); end
    tests++; if (!fo) begin fails++; $display("FAIL rst_relock_freq_count: last %0d expected 2046..2050", freq_count); end
  endtask

  task automatic test_wrap;
    int le, cf, cn;
    bit fo;
    lock_en = 1'b0;
    preload(32'd1046476);
    fb_limit = 0;
    fb_half = HALF_2048;
    fb_on = 1'b1;
    lock_en = 1'b1;
    run_to_lock(300, 2046, 2050, le, cf, cn, fo);
    tests++; if (!fo || cf !== 129) begin fails++; $display("FAIL wrap_delta: freq_count %0d first cv %0d expected 2046..2050 at 129", freq_count, cf); end
    tests++; if (le !== 258) begin fails++; $display("FAIL wrap_lock_edge: got %0d expected 258", le); end
  endtask

  initial begin
    test_reset();
    test_acquire();
    test_fb_loss();
    test_tolerance();
    test_lock_en_drop();
    test_reset_midwindow();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/gtxe2_comm_qpll_lockdet.md
# gtxe2_comm_qpll_lockdet

Frequency-based lock detector that consumes the QPLL's generated clock and decides whether the PLL is locked. It sits beside the QPLL model in gtxe2_common and drives QPLLLOCK and QPLLFBCLKLOST. It counts feedback-clock edges over a fixed window of ref_clk cycles and declares lock after N consecutive in-tolerance windows. The logic is synthesizable and replaces the delay-based lock estimate.

## Interface
Parameters:
- WINDOW, 1024: ref_clk cycles per measurement window, 2..65536.
- FB_EXPECT, 32768: expected fb_clk rising edges per window.
- TOLERANCE, 64: allowed absolute deviation from FB_EXPECT.
- LOCK_WINDOWS, 3: consecutive good windows required to lock, 1..15.
- CNT_W, 20: fb edge counter width. Must satisfy FB_EXPECT+TOLERANCE < 2^(CNT_W-1).

Ports:
- ref_clk, in, 1: reference clock. Every output is in this domain.
- reset, in, 1: reset, asynchronous, active-high. Also clears the fb_clk-domain counter.
- fb_clk, in, 1: QPLL output or feedback clock. Free-running or absent.
- lock_en, in, 1: QPLLLOCKEN. Low forces DISABLED.
- lock, out, 1: QPLLLOCK.
- fbclk_lost, out, 1: QPLLFBCLKLOST.
- freq_count, out, CNT_W: fb edges counted in the last completed window.
- count_valid, out, 1: one-cycle pulse when freq_count updates.

## Operation
- fb domain: a CNT_W binary counter increments on each fb_clk rise. A registered Gray copy is sent to ref_clk through 2 flops, then converted back to binary.
- ref domain: win_cnt runs 0..WINDOW-1 while lock_en=1. It is held at 0 while lock_en=0.
- At win_cnt==WINDOW-1, the synchronized value is captured and delta = captured − previous capture, computed modulo 2^CNT_W.
- The first window after reset or after lock_en rises is the baseline only. It produces no delta, no count_valid and no evaluation.
- A window is good when |delta − FB_EXPECT| ≤ TOLERANCE. Compare as signed CNT_W+1 bits.
- FSM states:
  - DISABLED: lock=0, good_cnt=0. Go to ACQUIRE when lock_en=1.
  - ACQUIRE: a good window increments good_cnt. A bad window clears it. At good_cnt==LOCK_WINDOWS, go to LOCKED.
  - LOCKED: lock=1. Any bad window clears good_cnt, drops lock and returns to ACQUIRE.
  - Any state: lock_en=0 returns to DISABLED at the next edge. The baseline is discarded.
- fbclk_lost:
  - Set when an evaluated delta is 0.
  - Cleared by the first evaluated nonzero delta.
  - Held while lock_en=0.
  - delta 0 is also a bad window.
- Reset values: lock=0, fbclk_lost=0, freq_count=0, count_valid=0, state DISABLED, win_cnt=0.

## Timing
- Cycle E is the ref_clk edge where win_cnt==WINDOW-1.
  - E+1: delta and freq_count registered, count_valid=1 for one cycle.
  - E+2: FSM, lock and fbclk_lost updated.
- Lock asserts at E+2 of the LOCK_WINDOWS-th consecutive good window. After lock_en rises this is at least (LOCK_WINDOWS+1)·WINDOW+2 cycles.
- Lock deasserts at E+2 of the first bad window. When lock_en falls, lock deasserts 1 cycle later.
- Synchronizer skew gives up to ±2 counts of measurement error. TOLERANCE must be set larger than that.
- Counter wrap is harmless because of modulo subtraction.
- Reset mid-window:
  - Everything clears at once.
  - The fb counter restarts from 0.
  - The next window is the baseline.
- When count_valid and a lock_en fall happen on the same edge, lock_en wins.

## Structure
- Shared package gtxe2_comm_qpll_pkg holds:
  - the FSM state encoding (DISABLED, ACQUIRE, LOCKED);
  - the default WINDOW, FB_EXPECT and TOLERANCE constants;
  - the bin2gray and gray2bin functions.
- One sub-module, gtxe2_gray_cnt_sync, contains:
  - the fb_clk binary counter and its Gray register;
  - the 2-flop ref_clk synchronizer;
  - the Gray-to-binary output.
- The top contains the window counter, the delta/compare pipeline and the FSM.

## Test plan
Bench settings: WINDOW=64, FB_EXPECT=2048, TOLERANCE=16, LOCK_WINDOWS=3, ref 10 ns.
- fb period 312.5 ps (2048 edges per window), lock_en=1 after reset -> count_valid each window with freq_count 2048±2. lock rises at E+2 of window 4.
- fb stopped after lock -> freq_count=0, then fbclk_lost=1 and lock=0 two cycles after that window ends. fb restarted -> fbclk_lost clears after the first nonzero window. lock returns 3 good windows later.
- fb at 2070 edges per window (out of tolerance) -> lock never asserts and good_cnt stays 0. 2060 edges per window -> locks.
- lock_en dropped mid-window while LOCKED -> lock=0 the next cycle, no count_valid. Re-enable -> baseline window, then 3 windows to lock.
- reset pulsed mid-window at counter value 2^20−100 (preloaded) -> all outputs 0 at once. Wrap across 2^20 produces a correct delta of 2048.
